// File: rtl/adc_sample_scheduler_pkg.sv
// Shared time format, scheduler state encoding and helpers
// for the ADC sample scheduler.
package adc_sample_scheduler_pkg;

  localparam int TIME_BITS  = 24;
  localparam int TIME_POINT = 0;

  typedef logic [TIME_BITS-1:0] TIME_FORMAT;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } sched_state_t;

  function automatic int unsigned dt_max(
    input int unsigned bits
  );
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Valid/ready bundle carrying captured samples
// to the capture/logging path.
interface adc_sample_scheduler_if #(
  parameter int SIG_BITS = 8
);
  import adc_sample_scheduler_pkg::*;

  logic                       samp_valid;
  logic                       samp_ready;
  logic signed [SIG_BITS-1:0] samp_data;
  TIME_FORMAT                 samp_time;
  logic                       samp_late;

  modport master (
    output samp_valid,
    output samp_data,
    output samp_time,
    output samp_late,
    input  samp_ready
  );

  modport slave (
    input  samp_valid,
    input  samp_data,
    input  samp_time,
    input  samp_late,
    output samp_ready
  );

endinterface

// File: rtl/adc_sample_scheduler_sample_out_reg.sv
// One-entry valid/ready output register; a capture into a
// full, unconsumed register is dropped and flagged.
module sample_out_reg
  import adc_sample_scheduler_pkg::*;
#(
  parameter int SIG_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap,
  input  logic signed [SIG_BITS-1:0] cap_data,
  input  TIME_FORMAT                 cap_time,
  input  logic                       cap_late,
  input  logic                       ready,
  output logic                       valid,
  output logic signed [SIG_BITS-1:0] data,
  output TIME_FORMAT                 stamp,
  output logic                       late,
  output logic                       load,
  output logic                       drop
);

  assign load = cap & (~valid | ready);
  assign drop = cap & valid & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      stamp <= '0;
      late  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= cap_data;
      stamp <= cap_time;
      late  <= cap_late;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Schedules ADC captures at offset + k*period in emulated time
// and steers the time manager onto each instant via dt_req.
module adc_sample_scheduler
  import adc_sample_scheduler_pkg::*;
#(
  parameter int SIG_BITS = 8,
  parameter int DT_BITS  = 10,
  parameter int CNT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  TIME_FORMAT                 offset,
  input  TIME_FORMAT                 period,
  input  TIME_FORMAT                 time_curr,
  input  logic signed [SIG_BITS-1:0] sig,
  output logic [DT_BITS-1:0]         dt_req,
  adc_sample_scheduler_if.master     samp,
  output logic [CNT_BITS-1:0]        samp_count,
  output logic [CNT_BITS-1:0]        drop_count,
  output logic                       overflow
);

  localparam logic [DT_BITS-1:0] DT_MAX =
    DT_BITS'(dt_max(DT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  sched_state_t           state_q, state_d;
  TIME_FORMAT             next_q, next_d;
  TIME_FORMAT             per_eff;
  TIME_FORMAT             d_raw;
  logic signed [TIME_BITS:0] diff;
  logic                   diff_pos;
  logic                   cap, cap_late;
  logic                   load, drop;

  function automatic logic [DT_BITS-1:0] sat_dt(
    input TIME_FORMAT v
  );
    if (v > TIME_FORMAT'(DT_MAX)) return DT_MAX;
    return v[DT_BITS-1:0];
  endfunction

  // Modular difference, sign-extended so wrap-around
  // instants still compare as "ahead".
  assign per_eff  = (period == '0) ? TIME_FORMAT'(1) : period;
  assign d_raw    = next_q - time_curr;
  assign diff     = {d_raw[TIME_BITS-1], d_raw};
  assign diff_pos = ~diff[TIME_BITS] & (|diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      next_q  <= '0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    dt_req   = DT_MAX;
    cap      = 1'b0;
    cap_late = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = ARM;
      end
      ARM: begin
        dt_req  = '0;
        next_d  = time_curr + offset;
        state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (diff_pos) begin
          dt_req = sat_dt(d_raw);
        end else begin
          cap      = 1'b1;
          cap_late = diff[TIME_BITS];
          next_d   = next_q + per_eff;
          dt_req   = sat_dt(per_eff);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sample_out_reg #(
    .SIG_BITS (SIG_BITS)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (cap),
    .cap_data (sig),
    .cap_time (time_curr),
    .cap_late (cap_late),
    .ready    (samp.samp_ready),
    .valid    (samp.samp_valid),
    .data     (samp.samp_data),
    .stamp    (samp.samp_time),
    .late     (samp.samp_late),
    .load     (load),
    .drop     (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load && samp_count != CNT_MAX)
        samp_count <= samp_count + 1'b1;
      if (drop && drop_count != CNT_MAX)
        drop_count <= drop_count + 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a stepping
// time-manager model.
module tb_adc_sample_scheduler;
  import adc_sample_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  TIME_FORMAT        offset;
  TIME_FORMAT        period;
  TIME_FORMAT        time_curr;
  logic signed [7:0] sig;
  logic [9:0]        dt_req;
  logic [15:0]       samp_count;
  logic [15:0]       drop_count;
  logic              overflow;
  logic              step_en;
  int                n_cmp = 0;
  int                n_bad = 0;

  adc_sample_scheduler_if #(.SIG_BITS(8)) samp_if();

  adc_sample_scheduler #(
    .SIG_BITS (8),
    .DT_BITS  (10),
    .CNT_BITS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .offset     (offset),
    .period     (period),
    .time_curr  (time_curr),
    .sig        (sig),
    .dt_req     (dt_req),
    .samp       (samp_if.master),
    .samp_count (samp_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // time_curr behaves like a register advanced by the dt_req
  // that was presented during the cycle.
  task automatic tick();
    logic [9:0] dtv;
    #1;
    dtv = dt_req;
    @(posedge clk);
    #1;
    if (step_en) time_curr = time_curr + TIME_FORMAT'(dtv);
    #1;
  endtask

  function automatic logic [31:0] d8(input logic signed [7:0] v);
    return {24'd0, v};
  endfunction

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    offset    = '0;
    period    = '0;
    time_curr = '0;
    sig       = '0;
    step_en   = 1'b0;
    samp_if.samp_ready = 1'b0;
    #2;
    chk("rst_dt", 32'(dt_req), 32'd1023);
    chk("rst_valid", 32'(samp_if.samp_valid), 32'd0);
    chk("rst_cnt", 32'(samp_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle, time stepping by 5
    repeat (3) begin
      tick();
      time_curr = time_curr + 24'd5;
    end
    chk("idle_dt", 32'(dt_req), 32'd1023);
    chk("idle_valid", 32'(samp_if.samp_valid), 32'd0);
    chk("idle_cnt", 32'(samp_count), 32'd0);
    chk("idle_drop", 32'(drop_count), 32'd0);

    // normal schedule: offset 100, period 50
    time_curr = '0;
    offset = 24'd100;
    period = 24'd50;
    samp_if.samp_ready = 1'b1;
    en = 1'b1;
    tick();
    chk("arm_dt", 32'(dt_req), 32'd0);
    step_en = 1'b1;
    tick();
    chk("run_dt100", 32'(dt_req), 32'd100);
    sig = 8'sd17;
    tick();
    chk("t100_time", 32'(time_curr), 32'd100);
    chk("t100_novalid", 32'(samp_if.samp_valid), 32'd0);
    chk("t100_dt", 32'(dt_req), 32'd50);
    tick();
    chk("c100_valid", 32'(samp_if.samp_valid), 32'd1);
    chk("c100_time", 32'(samp_if.samp_time), 32'd100);
    chk("c100_data", d8(samp_if.samp_data), 32'd17);
    chk("c100_late", 32'(samp_if.samp_late), 32'd0);
    sig = -8'sd5;
    tick();
    chk("c150_time", 32'(samp_if.samp_time), 32'd150);
    chk("c150_data", d8(samp_if.samp_data), 32'hFB);
    sig = 8'sd99;
    tick();
    chk("c200_time", 32'(samp_if.samp_time), 32'd200);
    chk("c200_late", 32'(samp_if.samp_late), 32'd0);
    chk("c200_cnt", 32'(samp_count), 32'd3);

    // disable: no capture in the en-low cycle
    en = 1'b0;
    step_en = 1'b0;
    tick();
    chk("dis_cnt", 32'(samp_count), 32'd3);
    chk("dis_valid", 32'(samp_if.samp_valid), 32'd0);

    // re-arm with next_time=150, then time jumps 140 -> 170
    time_curr = 24'd50;
    en = 1'b1;
    tick();
    tick();
    time_curr = 24'd140;
    #1;
    chk("pre_jump_dt", 32'(dt_req), 32'd10);
    time_curr = 24'd170;
    sig = 8'sd42;
    tick();
    chk("late_flag", 32'(samp_if.samp_late), 32'd1);
    chk("late_time", 32'(samp_if.samp_time), 32'd170);
    chk("late_cnt", 32'(samp_count), 32'd4);
    chk("late_next", 32'(dt_req), 32'd30);

    // back-pressure: two captures with ready low
    step_en = 1'b1;
    tick();
    chk("bp_drain", 32'(samp_if.samp_valid), 32'd0);
    samp_if.samp_ready = 1'b0;
    sig = 8'sd11;
    tick();
    chk("bp_first_time", 32'(samp_if.samp_time), 32'd200);
    sig = 8'sd22;
    tick();
    chk("bp_hold_data", d8(samp_if.samp_data), 32'd11);
    chk("bp_hold_time", 32'(samp_if.samp_time), 32'd200);
    chk("bp_drop", 32'(drop_count), 32'd1);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_cnt", 32'(samp_count), 32'd5);
    step_en = 1'b0;
    time_curr = 24'd280;
    samp_if.samp_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", 32'(samp_if.samp_valid), 32'd0);

    // simultaneous consume and capture
    step_en = 1'b1;
    tick();
    sig = 8'sd33;
    tick();
    chk("cc_first", 32'(samp_if.samp_time), 32'd300);
    sig = 8'sd44;
    tick();
    chk("cc_valid", 32'(samp_if.samp_valid), 32'd1);
    chk("cc_data", d8(samp_if.samp_data), 32'd44);
    chk("cc_time", 32'(samp_if.samp_time), 32'd350);
    chk("cc_drop", 32'(drop_count), 32'd1);
    chk("cc_cnt", 32'(samp_count), 32'd7);

    // period 0, offset 0: capture every cycle
    en = 1'b0;
    step_en = 1'b0;
    tick();
    period = '0;
    offset = '0;
    en = 1'b1;
    tick();
    tick();
    chk("p0_dt", 32'(dt_req), 32'd1);
    step_en = 1'b1;
    tick();
    chk("p0_t0", 32'(samp_if.samp_time), 32'd400);
    chk("p0_dt1", 32'(dt_req), 32'd1);
    tick();
    chk("p0_t1", 32'(samp_if.samp_time), 32'd401);
    chk("p0_cnt", 32'(samp_count), 32'd9);

    // asynchronous reset mid-RUN
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(samp_if.samp_valid), 32'd0);
    chk("ar_time", 32'(samp_if.samp_time), 32'd0);
    chk("ar_cnt", 32'(samp_count), 32'd0);
    chk("ar_drop", 32'(drop_count), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_dt", 32'(dt_req), 32'd1023);
    rst_n = 1'b1;

    // wrap-around
    step_en = 1'b0;
    time_curr = 24'hFFFFF6;
    offset = 24'd20;
    period = 24'd50;
    sig = 8'sd7;
    tick();
    chk("wr_arm_dt", 32'(dt_req), 32'd0);
    step_en = 1'b1;
    tick();
    chk("wr_dt", 32'(dt_req), 32'd20);
    tick();
    chk("wr_tc", 32'(time_curr), 32'd10);
    chk("wr_novalid", 32'(samp_if.samp_valid), 32'd0);
    tick();
    chk("wr_time", 32'(samp_if.samp_time), 32'd10);
    chk("wr_late", 32'(samp_if.samp_late), 32'd0);
    chk("wr_cnt", 32'(samp_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
